// File: rtl/updown_counter_pkg.sv
// Shared constants and step-decision helper for updown_counter.
// The helper is width-independent: callers supply the two range comparisons.
package updown_counter_pkg;

    localparam logic DIR_DOWN  = 1'b0;
    localparam logic DIR_UP    = 1'b1;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    typedef enum logic [2:0] {
        ACT_INC,
        ACT_DEC,
        ACT_WRAP_ZERO,
        ACT_WRAP_LIMIT,
        ACT_SAT_LIMIT,
        ACT_SAT_ZERO
    } step_act_e;

    // Up is terminal at count >= limit, down is terminal at count == 0.
    function automatic step_act_e step_action(input logic dir,
                                              input logic mode,
                                              input logic below_limit,
                                              input logic is_zero);
        step_act_e act;
        if (dir == DIR_UP) begin
            if (below_limit)            act = ACT_INC;
            else if (mode == MODE_SAT)  act = ACT_SAT_LIMIT;
            else                        act = ACT_WRAP_ZERO;
        end else begin
            if (!is_zero)               act = ACT_DEC;
            else if (mode == MODE_SAT)  act = ACT_SAT_ZERO;
            else                        act = ACT_WRAP_LIMIT;
        end
        return act;
    endfunction

endpackage

// File: rtl/updown_prescaler.sv
// Counts enabled cycles 0..PRESCALE-1 and flags the last one as a step tick.
// Holds while enable is low; clear_i (load) returns it to 0.
module updown_prescaler #(
    parameter int PRESCALE = 4
) (
    input  logic clock_i,
    input  logic reset_i,
    input  logic enable_i,
    input  logic clear_i,
    output logic tick_o
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] cnt_q;
    logic [PW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = enable_i && (cnt_q == LAST);

endmodule

// File: rtl/updown_counter.sv
// Up/down counter with load, programmable limit and wrap/saturate modes.
// Optional enabled-cycle prescaler compiled in by defining UPDN_COUNTER_PRESCALE_EN.
module updown_counter
    import updown_counter_pkg::*;
#(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b1}},
    parameter int               PRESCALE  = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             dir,
    input  logic             sat_mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             saturated,
    output logic             at_zero,
    output logic             at_limit
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             sat_q, sat_d;
    logic             step_tick;
    step_act_e        act;

`ifdef UPDN_COUNTER_PRESCALE_EN
    updown_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clock_i  (clock),
        .reset_i  (reset),
        .enable_i (enable),
        .clear_i  (load),
        .tick_o   (step_tick)
    );
`else
    assign step_tick = enable;
`endif

    assign act = step_action(dir, sat_mode, (count_q < limit), (count_q == '0));

    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        sat_d   = sat_q;
        if (load) begin
            count_d = load_val;
            sat_d   = 1'b0;
        end else if (step_tick) begin
            unique case (act)
                ACT_INC: begin
                    count_d = count_q + 1'b1;
                    sat_d   = 1'b0;
                end
                ACT_DEC: begin
                    count_d = count_q - 1'b1;
                    sat_d   = 1'b0;
                end
                ACT_WRAP_ZERO: begin
                    count_d = '0;
                    tc_d    = 1'b1;
                    sat_d   = 1'b0;
                end
                ACT_WRAP_LIMIT: begin
                    count_d = limit;
                    tc_d    = 1'b1;
                    sat_d   = 1'b0;
                end
                // Clamps an out-of-range count back to limit as well as holding.
                ACT_SAT_LIMIT: begin
                    count_d = limit;
                    sat_d   = 1'b1;
                end
                ACT_SAT_ZERO: begin
                    count_d = '0;
                    sat_d   = 1'b1;
                end
                default: begin
                    count_d = count_q;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= RESET_VAL;
            tc_q    <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            sat_q   <= sat_d;
        end
    end

    assign count     = count_q;
    assign tc        = tc_q;
    assign saturated = sat_q;
    assign at_zero   = (count_q == '0);
    assign at_limit  = (count_q == limit);

endmodule

// File: tb/tb_updown_counter.sv
// Directed scoreboard bench for updown_counter (WIDTH=4, default parameters).
module tb_updown_counter;

    logic       clock;
    logic       reset;
    logic       enable;
    logic       dir;
    logic       sat_mode;
    logic       load;
    logic [3:0] load_val;
    logic [3:0] limit;
    logic [3:0] count;
    logic       tc;
    logic       saturated;
    logic       at_zero;
    logic       at_limit;

    logic       sample_now;

    typedef struct {
        string      name;
        logic [3:0] cnt;
        logic       tc;
        logic       sat;
        logic       az;
        logic       al;
    } exp_t;

    exp_t exp_q[$];
    int   vectors;
    int   miscompares;

    updown_counter dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .dir       (dir),
        .sat_mode  (sat_mode),
        .load      (load),
        .load_val  (load_val),
        .limit     (limit),
        .count     (count),
        .tc        (tc),
        .saturated (saturated),
        .at_zero   (at_zero),
        .at_limit  (at_limit)
    );

    initial begin
        clock = 1'b0;
        #15;
        forever #5 clock = ~clock;
    end

    task automatic push_exp(input string nm, input logic [3:0] ec, input logic etc,
                            input logic es, input logic [3:0] lim);
        exp_t e;
        e.name = nm;
        e.cnt  = ec;
        e.tc   = etc;
        e.sat  = es;
        e.az   = (ec == 4'd0);
        e.al   = (ec == lim);
        exp_q.push_back(e);
    endtask

    // Drives one cycle of inputs at the falling edge; the result is due after the next rising edge.
    task automatic apply(input string nm, input logic en, input logic d, input logic s,
                         input logic ld, input logic [3:0] ldv, input logic [3:0] lim,
                         input logic [3:0] ec, input logic etc, input logic es);
        @(negedge clock);
        enable   = en;
        dir      = d;
        sat_mode = s;
        load     = ld;
        load_val = ldv;
        limit    = lim;
        push_exp(nm, ec, etc, es, lim);
    endtask

    // Checks an asynchronous effect without waiting for a clock edge.
    task automatic async_check(input string nm, input logic [3:0] ec);
        push_exp(nm, ec, 1'b0, 1'b0, limit);
        sample_now = 1'b1;
        #2;
        sample_now = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        vectors     = 0;
        miscompares = 0;
        forever begin
            @(posedge clock or posedge sample_now);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                if ({count, tc, saturated, at_zero, at_limit} !== {e.cnt, e.tc, e.sat, e.az, e.al}) begin
                    miscompares++;
                    $display("FAIL %s (vector %0d): count/tc/sat/at_zero/at_limit got %0d/%b/%b/%b/%b want %0d/%b/%b/%b/%b",
                             e.name, vectors, count, tc, saturated, at_zero, at_limit,
                             e.cnt, e.tc, e.sat, e.az, e.al);
                end
            end
        end
    end

    initial begin : stimulus
        reset      = 1'b0;
        enable     = 1'b0;
        dir        = 1'b0;
        sat_mode   = 1'b0;
        load       = 1'b0;
        load_val   = 4'd0;
        limit      = 4'd15;
        sample_now = 1'b0;

        #1;
        reset = 1'b1;
        async_check("reset_async", 4'd15);
        #8;
        reset = 1'b0;

`ifdef UPDN_COUNTER_PRESCALE_EN
        apply("ps_load", 0, 1, 0, 1, 4'd0, 4'd15, 4'd0, 0, 0);
        apply("ps_c1",   1, 1, 0, 0, 4'd0, 4'd15, 4'd0, 0, 0);
        apply("ps_c2",   1, 1, 0, 0, 4'd0, 4'd15, 4'd0, 0, 0);
        apply("ps_c3",   1, 1, 0, 0, 4'd0, 4'd15, 4'd0, 0, 0);
        apply("ps_c4",   1, 1, 0, 0, 4'd0, 4'd15, 4'd1, 0, 0);
        apply("ps_idle", 0, 1, 0, 0, 4'd0, 4'd15, 4'd1, 0, 0);
        apply("ps_c5",   1, 1, 0, 0, 4'd0, 4'd15, 4'd1, 0, 0);
        apply("ps_c6",   1, 1, 0, 0, 4'd0, 4'd15, 4'd1, 0, 0);
        apply("ps_c7",   1, 1, 0, 0, 4'd0, 4'd15, 4'd1, 0, 0);
        apply("ps_c8",   1, 1, 0, 0, 4'd0, 4'd15, 4'd2, 0, 0);
        apply("ps_c9",   1, 1, 0, 0, 4'd0, 4'd15, 4'd2, 0, 0);
        apply("ps_c10",  1, 1, 0, 0, 4'd0, 4'd15, 4'd2, 0, 0);
        @(negedge clock);
        enable = 1'b0;
        reset  = 1'b1;
        async_check("ps_reset_mid", 4'd15);
        @(negedge clock);
        reset = 1'b0;
        apply("ps_r1", 1, 1, 0, 0, 4'd0, 4'd15, 4'd15, 0, 0);
        apply("ps_r2", 1, 1, 0, 0, 4'd0, 4'd15, 4'd15, 0, 0);
        apply("ps_r3", 1, 1, 0, 0, 4'd0, 4'd15, 4'd15, 0, 0);
        apply("ps_r4", 1, 1, 0, 0, 4'd0, 4'd15, 4'd0,  1, 0);
        apply("ps_r5", 1, 1, 0, 0, 4'd0, 4'd15, 4'd0,  0, 0);
`else
        for (int v = 14; v >= 0; v--)
            apply("down_wrap", 1, 0, 0, 0, 4'd0, 4'd15, 4'(v), 0, 0);
        apply("down_wrap_tc",   1, 0, 0, 0, 4'd0, 4'd15, 4'd15, 1, 0);
        apply("down_wrap_post", 1, 0, 0, 0, 4'd0, 4'd15, 4'd14, 0, 0);

        apply("sat_load",  0, 1, 1, 1, 4'd7, 4'd9, 4'd7, 0, 0);
        apply("sat_up8",   1, 1, 1, 0, 4'd0, 4'd9, 4'd8, 0, 0);
        apply("sat_up9",   1, 1, 1, 0, 4'd0, 4'd9, 4'd9, 0, 0);
        apply("sat_hold1", 1, 1, 1, 0, 4'd0, 4'd9, 4'd9, 0, 1);
        apply("sat_hold2", 1, 1, 1, 0, 4'd0, 4'd9, 4'd9, 0, 1);
        apply("sat_flip",  1, 0, 1, 0, 4'd0, 4'd9, 4'd8, 0, 0);

        apply("clamp_load", 0, 1, 1, 1, 4'd13, 4'd9, 4'd13, 0, 0);
        apply("clamp_up",   1, 1, 1, 0, 4'd0,  4'd9, 4'd9,  0, 1);

        apply("ld_12",      0, 0, 0, 1, 4'd12, 4'd9, 4'd12, 0, 0);
        apply("ld_over_en", 1, 0, 0, 1, 4'd3,  4'd9, 4'd3,  0, 0);
        apply("ld_12b",     1, 0, 0, 1, 4'd12, 4'd5, 4'd12, 0, 0);
        for (int v = 11; v >= 0; v--)
            apply("down_lim5", 1, 0, 0, 0, 4'd0, 4'd5, 4'(v), 0, 0);
        apply("down_lim5_wrap", 1, 0, 0, 0, 4'd0, 4'd5, 4'd5, 1, 0);

        apply("lim0_up_a", 1, 1, 0, 0, 4'd0, 4'd0, 4'd0, 1, 0);
        apply("lim0_up_b", 1, 1, 0, 0, 4'd0, 4'd0, 4'd0, 1, 0);
        apply("lim0_up_c", 1, 1, 0, 0, 4'd0, 4'd0, 4'd0, 1, 0);
        apply("lim0_off",  0, 1, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0);
        apply("lim0_up_d", 1, 1, 0, 0, 4'd0, 4'd0, 4'd0, 1, 0);
        apply("lim0_dn",   1, 0, 0, 0, 4'd0, 4'd0, 4'd0, 1, 0);
        apply("lim0_sat",  1, 0, 1, 0, 4'd0, 4'd0, 4'd0, 0, 1);

        apply("fr_load", 0, 1, 0, 1, 4'd14, 4'd15, 4'd14, 0, 0);
        apply("fr_up15", 1, 1, 0, 0, 4'd0,  4'd15, 4'd15, 0, 0);
        apply("fr_wrap", 1, 1, 0, 0, 4'd0,  4'd15, 4'd0,  1, 0);
        apply("fr_up1",  1, 1, 0, 0, 4'd0,  4'd15, 4'd1,  0, 0);

        apply("sd_load",  0, 0, 1, 1, 4'd1, 4'd15, 4'd1, 0, 0);
        apply("sd_to0",   1, 0, 1, 0, 4'd0, 4'd15, 4'd0, 0, 0);
        apply("sd_held",  1, 0, 1, 0, 4'd0, 4'd15, 4'd0, 0, 1);
        apply("sd_idle",  0, 0, 1, 0, 4'd0, 4'd15, 4'd0, 0, 1);
        apply("sd_up",    1, 1, 1, 0, 4'd0, 4'd15, 4'd1, 0, 0);
`endif

        @(negedge clock);
        enable = 1'b0;
        load   = 1'b0;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++)
            @(negedge clock);
        if (exp_q.size() > 0) begin
            $display("FAIL drain: %0d expected vectors never checked", exp_q.size());
            $fatal(1, "scoreboard did not drain");
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
